mem_stack_sequencer: RTL and testbench
======================================

Name: mem_stack_sequencer

Overview:
- Owns the single 16-bit data-memory port in the MEM stage and sequences it.
- Passes through ordinary load/store and single-word PUSH/POP.
- Expands CALL/INT/RET/RTI into multi-cycle word transfers, stalling the pipeline while it does so.
- Holds the stack pointer, reassembles popped PC/flags, and flags stack overflow/underflow.

Parameters:
- ADDR_W, 32, memory address and SP width
- DATA_W, 16, memory word width
- SP_RESET, 32'h000F_FFFF, SP value after reset (empty stack)
- STACK_LIMIT, 32'h000F_F000, lowest legal push address

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command present from EX/MEM
- cmd_op  in  3  0 LDST, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as no-op)
- req_addr  in  ADDR_W  load/store address
- req_wdata  in  DATA_W  store/PUSH data
- req_mr  in  1  load request (LDST only)
- req_mw  in  1  store request (LDST only)
- pc_in  in  32  return PC for CALL/INT
- flags_in  in  3  flags for INT
- mem_rdata  in  DATA_W  memory read data (combinational read)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mr  out  1  memory read enable
- mem_mw  out  1  memory write enable
- stall  out  1  hold IF..EX/MEM; combinational
- pop_data  out  DATA_W  POP/load result, same cycle as read
- pc_out  out  32  reassembled PC (registered)
- pc_valid  out  1  one-cycle pulse, pc_out valid
- flags_out  out  3  restored flags (registered)
- flags_valid  out  1  one-cycle pulse, flags_out valid
- sp_out  out  ADDR_W  current SP
- stack_err  out  1  sticky over/underflow

Behaviour:
- Reset: async on rst_n low. State S_IDLE, SP=SP_RESET. pc_out=0, flags_out=0, pc_valid=0, flags_valid=0, stack_err=0. Memory enables 0. Reset mid-sequence aborts it with no further memory access.
- Stack discipline:
  - Push writes at SP, then SP<=SP-1.
  - Pop sets SP<=SP+1 and reads at SP+1 (address presented combinationally).
- LDST: mem_addr=req_addr, mem_mr=req_mr, mem_mw=req_mw, mem_wdata=req_wdata, pop_data=mem_rdata. No stall, SP unchanged.
- PUSH/POP: one cycle, no stall.
- Word order:
  - CALL: PC[31:16], then PC[15:0].
  - INT: PC[31:16], PC[15:0], then {13'b0,flags}.
  - RET: pop PC[15:0], then PC[31:16].
  - RTI: pop flags, PC[15:0], then PC[31:16].
- FSM states: S_IDLE, S_W2, S_W3.
  - Word 1 executes in S_IDLE, in the cycle cmd_valid is seen.
  - 2-word ops: S_IDLE -> S_W2 -> S_IDLE. Stall=1 in the word-1 cycle only.
  - 3-word ops: S_IDLE -> S_W2 -> S_W3 -> S_IDLE. Stall=1 in the word-1 and word-2 cycles.
  - Stall=0 in the final-word cycle.
  - pc_in, flags_in and cmd_op are captured in word 1; later words use the captured copies. Upstream holds inputs stable while stall=1.
- Reassembly:
  - Popped low word goes to an internal 16-bit latch.
  - On the final RET/RTI word, pc_out<={mem_rdata,lo}, and pc_valid pulses the next cycle.
  - RTI: flags_out<=mem_rdata[2:0] on word 1; flags_valid pulses the cycle after the final word, together with pc_valid.
- Errors:
  - Push with SP<STACK_LIMIT, or pop with SP==SP_RESET, sets stack_err.
  - The offending word is suppressed: mem_mr=mem_mw=0, SP unchanged.
  - The sequence terminates: FSM returns to S_IDLE, stall=0 that cycle, no pc_valid/flags_valid.
  - stack_err clears only on reset.
- SP arithmetic is modulo 2^ADDR_W. Wrap is only reachable via a mis-set parameter and is not otherwise guarded.
- cmd_valid in S_W2/S_W3 is ignored; the in-flight sequence has priority.
- Op 7 and cmd_valid=0: all enables 0, no state change.

Decomposition:
- Package mem_seq_pkg:
  - cmd_op encodings (OP_LDST..OP_RTI)
  - FSM state encodings
  - default SP_RESET/STACK_LIMIT constants
- Sub-module stack_pointer_unit:
  - SP register with push/pop strobes
  - returns current/next address
  - provides full/empty compares against parameters

Test Plan:
- Reset, then CALL pc_in=32'h0001_2345:
  - cycle0: mw at 0x000FFFFF data 0x0001, stall=1.
  - cycle1: mw at 0x000FFFFE data 0x2345, stall=0.
  - SP=0x000FFFFD.
- RET after the CALL:
  - reads 0x000FFFFE then 0x000FFFFF, stall=1 then 0.
  - next cycle pc_out=0x0001_2345, pc_valid=1 for one cycle, SP=0x000FFFFF.
- INT pc=0xABCD_0010, flags=3'b101, then RTI:
  - INT: three writes (0xABCD, 0x0010, 0x0005), stall 1,1,0.
  - RTI: flags_out=3'b101 and pc_out=0xABCD_0010, with flags_valid and pc_valid in the same cycle.
- POP from reset SP:
  - stack_err=1, mem_mr=0, SP unchanged.
  - following LDST req_addr=0x20 req_mw=1 passes through.
- Assert rst_n=0 during S_W2 of INT:
  - all outputs return to reset values immediately, stall=0, SP=SP_RESET.
  - no third write is seen.
- LDST load addr 0x40 with mem_rdata=0xBEEF:
  - pop_data=0xBEEF same cycle, stall=0, SP unchanged.

Source files
------------

// File: rtl/mem_stack_sequencer_pkg.sv
// Package for the MEM-stage stack sequencer.
// Holds the command opcode encodings, the FSM state encodings, the default
// stack-pointer constants and a helper that gives the word count of each op.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    OP_LDST = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W2   = 2'd1,
    S_W3   = 2'd2
  } state_e;

  localparam logic [31:0] SP_RESET_DEF    = 32'h000F_FFFF;
  localparam logic [31:0] STACK_LIMIT_DEF = 32'h000F_F000;

  // Number of memory words an op moves; single-word and no-op commands
  // report 1 so that their only cycle counts as the final one.
  function automatic logic [1:0] op_words(op_e op);
    case (op)
      OP_CALL, OP_RET: return 2'd2;
      OP_INT,  OP_RTI: return 2'd3;
      default:         return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stack_sequencer_if.sv
// Data-memory port bundle for the MEM stage.
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_mr    : read enable
//   mem_mw    : write enable
//   mem_rdata : combinational read data from the memory
// master = sequencer side, slave = memory side.
interface mem_stack_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_mr;
  logic              mem_mw;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_mr, mem_mw,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_mr, mem_mw,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stack_sequencer_sp.sv
// Stack pointer register for the MEM-stage sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (SP <= SP_RESET)
//   push, pop  : one-cycle strobes; push decrements SP, pop increments it
//   sp         : current SP (address of the next push)
//   sp_inc     : SP+1 (address of the next pop)
//   full       : SP below the lowest legal push address
//   empty      : SP at its reset value, nothing to pop
module stack_pointer_unit
  import mem_seq_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] SP_RESET    = SP_RESET_DEF[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_inc,
  output logic              full,
  output logic              empty
);

  // Arithmetic wraps modulo 2^ADDR_W; only a mis-set parameter reaches it.
  assign sp_inc = sp + ADDR_W'(1);
  assign full   = (sp < STACK_LIMIT);
  assign empty  = (sp == SP_RESET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_RESET;
    end else if (push) begin
      sp <= sp - ADDR_W'(1);
    end else if (pop) begin
      sp <= sp_inc;
    end
  end

endmodule

// File: rtl/mem_stack_sequencer.sv
// MEM-stage data-memory sequencer.
// Owns the single data-memory port: passes LDST and single-word PUSH/POP
// straight through and expands CALL/INT (pushes) and RET/RTI (pops) into
// multi-word sequences, stalling the upstream pipeline meanwhile.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid, cmd_op   : command from EX/MEM (op 7 is a no-op)
//   req_addr/wdata/mr/mw: load/store request, req_wdata also feeds PUSH
//   pc_in, flags_in     : return PC and flags captured on CALL/INT
//   bus                 : data-memory port (master side)
//   stall               : combinational hold for IF..EX/MEM
//   pop_data            : read data, same cycle as the read
//   pc_out/pc_valid     : reassembled return PC, one-cycle pulse
//   flags_out/flags_valid: restored flags, pulse alongside pc_valid
//   sp_out              : current stack pointer
//   stack_err           : sticky overflow/underflow flag
module mem_stack_sequencer
  import mem_seq_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] SP_RESET    = SP_RESET_DEF[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF[ADDR_W-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  req_mr,
  input  logic                  req_mw,
  input  logic [31:0]           pc_in,
  input  logic [2:0]            flags_in,
  mem_stack_sequencer_if.master bus,
  output logic                  stall,
  output logic [DATA_W-1:0]     pop_data,
  output logic [31:0]           pc_out,
  output logic                  pc_valid,
  output logic [2:0]            flags_out,
  output logic                  flags_valid,
  output logic [ADDR_W-1:0]     sp_out,
  output logic                  stack_err
);

  state_e            state;
  op_e               op_p1;
  logic [31:0]       pc_p1;
  logic [2:0]        flags_p1;
  logic [DATA_W-1:0] lo_p1;

  op_e               op_cur;
  logic [1:0]        word;
  logic              active;
  logic [31:0]       pc_cur;
  logic [2:0]        flags_cur;
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_word;
  logic              last;
  logic              err;
  logic              do_push;
  logic              do_pop;
  logic              ldst;

  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_inc;
  logic              full;
  logic              empty;

  stack_pointer_unit #(
    .ADDR_W      (ADDR_W),
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (do_push),
    .pop    (do_pop),
    .sp     (sp),
    .sp_inc (sp_inc),
    .full   (full),
    .empty  (empty)
  );

  // Word decode: word 1 runs from the live inputs in S_IDLE, later words
  // from the copies captured in word 1. Gated by rst_n so an asserted reset
  // drops every enable at once, even with cmd_valid still high.
  always_comb begin
    op_cur    = OP_RSVD;
    word      = 2'd0;
    active    = 1'b0;
    pc_cur    = pc_p1;
    flags_cur = flags_p1;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            active    = 1'b1;
            op_cur    = op_e'(cmd_op);
            word      = 2'd1;
            pc_cur    = pc_in;
            flags_cur = flags_in;
          end
        end
        S_W2: begin
          active = 1'b1;
          op_cur = op_p1;
          word   = 2'd2;
        end
        S_W3: begin
          active = 1'b1;
          op_cur = op_p1;
          word   = 2'd3;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    push_req  = 1'b0;
    pop_req   = 1'b0;
    push_word = req_wdata;
    case (op_cur)
      OP_PUSH: push_req = active;
      OP_POP:  pop_req  = active;
      OP_CALL: begin
        push_req  = active;
        push_word = (word == 2'd1) ? DATA_W'(pc_cur[31:16]) : DATA_W'(pc_cur[15:0]);
      end
      OP_INT: begin
        push_req = active;
        case (word)
          2'd1:    push_word = DATA_W'(pc_cur[31:16]);
          2'd2:    push_word = DATA_W'(pc_cur[15:0]);
          default: push_word = DATA_W'(flags_cur);
        endcase
      end
      OP_RET, OP_RTI: pop_req = active;
      default: ;
    endcase
  end

  assign last    = (word == op_words(op_cur));
  // An offending word is dropped entirely and ends the sequence.
  assign err     = (push_req & full) | (pop_req & empty);
  assign do_push = push_req & ~err;
  assign do_pop  = pop_req & ~err;
  assign ldst    = active & (op_cur == OP_LDST);

  assign bus.mem_addr  = do_push ? sp : (do_pop ? sp_inc : req_addr);
  assign bus.mem_wdata = do_push ? push_word : req_wdata;
  assign bus.mem_mw    = do_push | (ldst & req_mw);
  assign bus.mem_mr    = do_pop | (ldst & req_mr);

  assign stall    = active & ~last & ~err;
  assign pop_data = bus.mem_rdata;
  assign sp_out   = sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_p1       <= OP_LDST;
      pc_p1       <= '0;
      flags_p1    <= '0;
      lo_p1       <= '0;
      pc_out      <= '0;
      pc_valid    <= 1'b0;
      flags_out   <= '0;
      flags_valid <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      pc_valid    <= 1'b0;
      flags_valid <= 1'b0;
      if (err) begin
        stack_err <= 1'b1;
      end
      if ((state == S_IDLE) && cmd_valid) begin
        op_p1    <= op_e'(cmd_op);
        pc_p1    <= pc_in;
        flags_p1 <= flags_in;
      end
      // Popped words: low PC half parks in lo_p1 until the high half arrives.
      if (do_pop) begin
        case (op_cur)
          OP_RET: begin
            if (word == 2'd1) begin
              lo_p1 <= bus.mem_rdata;
            end else begin
              pc_out   <= {bus.mem_rdata, lo_p1};
              pc_valid <= 1'b1;
            end
          end
          OP_RTI: begin
            case (word)
              2'd1: flags_out <= bus.mem_rdata[2:0];
              2'd2: lo_p1 <= bus.mem_rdata;
              default: begin
                pc_out      <= {bus.mem_rdata, lo_p1};
                pc_valid    <= 1'b1;
                flags_valid <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
      if (active && !err && !last) begin
        state <= (word == 2'd1) ? S_W2 : S_W3;
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_stack_sequencer.sv
module tb_mem_stack_sequencer;
  import mem_seq_pkg::*;

  localparam logic [31:0] SPR = 32'h000F_FFFF;
  localparam logic [31:0] LIM = 32'h000F_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd7;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_mr = 1'b0;
  logic        req_mw = 1'b0;
  logic [31:0] pc_in = '0;
  logic [2:0]  flags_in = '0;
  logic        stall;
  logic [15:0] pop_data;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  flags_out;
  logic        flags_valid;
  logic [31:0] sp_out;
  logic        stack_err;

  always #5 clk = ~clk;

  mem_stack_sequencer_if #(.ADDR_W(32), .DATA_W(16)) bus ();

  mem_stack_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_mr      (req_mr),
    .req_mw      (req_mw),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .bus         (bus),
    .stall       (stall),
    .pop_data    (pop_data),
    .pc_out      (pc_out),
    .pc_valid    (pc_valid),
    .flags_out   (flags_out),
    .flags_valid (flags_valid),
    .sp_out      (sp_out),
    .stack_err   (stack_err)
  );

  // Memory: low addresses (LDST) and the stack window share one array.
  logic [15:0] tmem [0:8191];

  function automatic logic [12:0] midx(input logic [31:0] a);
    return {a >= LIM, a[11:0]};
  endfunction

  always_comb bus.mem_rdata = tmem[midx(bus.mem_addr)];

  always @(posedge clk) begin
    if (bus.mem_mw) tmem[midx(bus.mem_addr)] <= bus.mem_wdata;
  end

  // Scoreboard
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] data;
    logic        stl;
  } acc_t;

  typedef struct {
    logic [31:0] pc;
    logic        has_f;
    logic [2:0]  f;
  } ret_t;

  acc_t exp_acc[$];
  ret_t exp_ret[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: the stack is a queue of words, SP is derived from depth.
  logic [15:0] stk[$];
  logic        m_err = 1'b0;
  logic [15:0] mmem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_push(input logic [15:0] w, input logic stl);
    logic [31:0] a;
    a = SPR - 32'(stk.size());
    if (a < LIM) begin
      m_err = 1'b1;
      return 1'b0;
    end
    exp_acc.push_back('{1'b1, a, w, stl});
    stk.push_back(w);
    return 1'b1;
  endfunction

  function automatic bit m_pop(output logic [15:0] w, input logic stl);
    logic [31:0] a;
    w = '0;
    if (stk.size() == 0) begin
      m_err = 1'b1;
      return 1'b0;
    end
    a = SPR - 32'(stk.size()) + 32'd1;
    w = stk.pop_back();
    exp_acc.push_back('{1'b0, a, w, stl});
    return 1'b1;
  endfunction

  function automatic void model_cmd(input logic [2:0] op, input logic [31:0] a,
                                    input logic [15:0] wd, input logic mr, input logic mw,
                                    input logic [31:0] pc, input logic [2:0] fl);
    logic [15:0] w, lo, hi, fw;
    case (op)
      3'd0: begin
        if (mw) begin
          mmem[a] = wd;
          exp_acc.push_back('{1'b1, a, wd, 1'b0});
        end else if (mr) begin
          exp_acc.push_back('{1'b0, a, mmem.exists(a) ? mmem[a] : 16'h0, 1'b0});
        end
      end
      3'd1: void'(m_push(wd, 1'b0));
      3'd2: void'(m_pop(w, 1'b0));
      3'd3: if (m_push(pc[31:16], 1'b1)) void'(m_push(pc[15:0], 1'b0));
      3'd5: if (m_push(pc[31:16], 1'b1))
              if (m_push(pc[15:0], 1'b1))
                void'(m_push({13'b0, fl}, 1'b0));
      3'd4: if (m_pop(lo, 1'b1))
              if (m_pop(hi, 1'b0))
                exp_ret.push_back('{{hi, lo}, 1'b0, 3'b0});
      3'd6: if (m_pop(fw, 1'b1))
              if (m_pop(lo, 1'b1))
                if (m_pop(hi, 1'b0))
                  exp_ret.push_back('{{hi, lo}, 1'b1, fw[2:0]});
      default: ;
    endcase
  endfunction

  // Monitor: compares every memory access and every return pulse.
  always @(negedge clk) begin : monitor
    acc_t e;
    ret_t r;
    if (bus.mem_mr || bus.mem_mw) begin
      if (exp_acc.size() == 0) begin
        chk("unexpected_access", {bus.mem_mw, bus.mem_mr, bus.mem_addr[29:0]}, 32'd0);
      end else begin
        e = exp_acc.pop_front();
        chk("acc_mw", 32'(bus.mem_mw), 32'(e.wr));
        chk("acc_mr", 32'(bus.mem_mr), 32'(!e.wr));
        chk("acc_addr", bus.mem_addr, e.addr);
        if (e.wr) chk("acc_wdata", 32'(bus.mem_wdata), 32'(e.data));
        else      chk("pop_data", 32'(pop_data), 32'(e.data));
        chk("acc_stall", 32'(stall), 32'(e.stl));
      end
    end else begin
      chk("idle_stall", 32'(stall), 32'd0);
    end
    if (pc_valid || flags_valid) begin
      if (exp_ret.size() == 0) begin
        chk("unexpected_pc_valid", {30'd0, pc_valid, flags_valid}, 32'd0);
      end else begin
        r = exp_ret.pop_front();
        chk("pc_valid", 32'(pc_valid), 32'd1);
        chk("pc_out", pc_out, r.pc);
        chk("flags_valid", 32'(flags_valid), 32'(r.has_f));
        if (r.has_f) chk("flags_out", 32'(flags_out), 32'(r.f));
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic [31:0] pc, input logic [2:0] fl);
    logic s;
    int   k;
    model_cmd(op, a, wd, mr, mw, pc, fl);
    cmd_valid = 1'b1;
    cmd_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_mr    = mr;
    req_mw    = mw;
    pc_in     = pc;
    flags_in  = fl;
    k = 0;
    do begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      k++;
    end while (s && k < 5);
    if (s) chk("stall_timeout", 32'(s), 32'd0);
    chk("sp_out", sp_out, SPR - 32'(stk.size()));
    chk("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    stk.delete();
    m_err = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, pc;
    logic [15:0] wd;
    logic [2:0]  op;
    int          p;
    logic        mr, mw;

    for (int i = 0; i < 8192; i++) tmem[i] = 16'h0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", sp_out, SPR);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mr", 32'(bus.mem_mr), 32'd0);
    chk("rst_mw", 32'(bus.mem_mw), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    chk("rst_flags_out", 32'(flags_out), 32'd0);
    chk("rst_flags_valid", 32'(flags_valid), 32'd0);
    chk("rst_stack_err", 32'(stack_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // CALL then RET
    issue(3'd3, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0001_2345, 3'd0);
    chk("call_sp", sp_out, 32'h000F_FFFD);
    issue(3'd4, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("ret_pc_out", pc_out, 32'h0001_2345);
    chk("ret_pc_valid", 32'(pc_valid), 32'd1);
    chk("ret_sp", sp_out, 32'h000F_FFFF);
    idle(1);
    chk("ret_pc_valid_pulse", 32'(pc_valid), 32'd0);

    // INT then RTI
    issue(3'd5, 32'h0, 16'h0, 1'b0, 1'b0, 32'hABCD_0010, 3'b101);
    issue(3'd6, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("rti_pc_out", pc_out, 32'hABCD_0010);
    chk("rti_flags_out", 32'(flags_out), 32'd5);
    chk("rti_flags_valid", 32'(flags_valid), 32'd1);
    idle(1);

    // POP from empty stack, then LDST store still passes through
    issue(3'd2, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("underflow_err", 32'(stack_err), 32'd1);
    chk("underflow_sp", sp_out, SPR);
    issue(3'd0, 32'h20, 16'h1234, 1'b0, 1'b1, 32'h0, 3'd0);

    // LDST load returns data the same cycle
    issue(3'd0, 32'h40, 16'hBEEF, 1'b0, 1'b1, 32'h0, 3'd0);
    issue(3'd0, 32'h40, 16'h0, 1'b1, 1'b0, 32'h0, 3'd0);
    idle(1);

    // Randomized command stream
    for (int n = 0; n < 400; n++) begin
      p  = int'($urandom_range(0, 99));
      if (p < 25)      op = 3'd0;
      else if (p < 45) op = 3'd1;
      else if (p < 60) op = 3'd2;
      else if (p < 70) op = 3'd3;
      else if (p < 80) op = 3'd4;
      else if (p < 88) op = 3'd5;
      else if (p < 95) op = 3'd6;
      else             op = 3'd7;
      a  = 32'($urandom_range(0, 255));
      wd = 16'($urandom);
      pc = $urandom;
      p  = int'($urandom_range(0, 2));
      mr = (p == 1);
      mw = (p == 2);
      issue(op, a, wd, mr, mw, pc, 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    chk("ret_queue_drained", 32'(exp_ret.size()), 32'd0);

    // Overflow: fill to the limit, then one more push and a CALL fail
    do_reset();
    for (int n = 0; n < 4096; n++) issue(3'd1, 32'h0, 16'($urandom), 1'b0, 1'b0, 32'h0, 3'd0);
    chk("fill_err_clear", 32'(stack_err), 32'd0);
    issue(3'd1, 32'h0, 16'hDEAD, 1'b0, 1'b0, 32'h0, 3'd0);
    chk("overflow_err", 32'(stack_err), 32'd1);
    chk("overflow_sp", sp_out, LIM - 32'd1);
    issue(3'd3, 32'h0, 16'h0, 1'b0, 1'b0, 32'h5555_6666, 3'd0);
    issue(3'd2, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0, 3'd0);
    idle(2);

    // Reset during the second word of INT
    do_reset();
    exp_acc.push_back('{1'b1, SPR, 16'h1111, 1'b1});
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    pc_in     = 32'h1111_2222;
    flags_in  = 3'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    stk.delete();
    m_err = 1'b0;
    #1;
    chk("abort_mw", 32'(bus.mem_mw), 32'd0);
    chk("abort_mr", 32'(bus.mem_mr), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_sp", sp_out, SPR);
    chk("abort_pc_valid", 32'(pc_valid), 32'd0);
    chk("abort_stack_err", 32'(stack_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    chk("abort_sp_after", sp_out, SPR);
    chk("final_acc_queue", 32'(exp_acc.size()), 32'd0);
    chk("final_ret_queue", 32'(exp_ret.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
